mem_port_ctrl: RTL and testbench
================================

Name: mem_port_ctrl

Overview:
- Multi-cycle memory port controller sitting between the CPU core and the single shared memory bus (readM/writeM/address/inout data/inputReady/ackOutput).
- Successor to the core's direct memory hookup: the core gets two request channels, instruction fetch (read-only) and data (read/write).
- Arbitrates between the channels and runs one bus transaction at a time with a full handshake.
- Adds parametrised widths, a selectable arbitration mode and a timeout/error response, none of which exist today.

Parameters:
- WORD_SIZE, 16, data bus and word width in bits.
- ADDR_SIZE, 16, address width in bits.
- TIMEOUT, 255, max wait cycles for inputReady/ackOutput; 0 disables the timeout.
- ARB_MODE, 0, 0 = data channel has fixed priority; 1 = round-robin between channels.

Ports:
- clk  in  1  Single clock; all state changes on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- if_req_valid  in  1  Fetch request.
- if_req_addr  in  ADDR_SIZE  Fetch address.
- if_req_ready  out  1  Fetch request accepted this cycle.
- if_rsp_valid  out  1  One-cycle fetch response pulse.
- if_rsp_data  out  WORD_SIZE  Fetched word.
- if_rsp_err  out  1  Fetch timed out.
- dm_req_valid  in  1  Data request.
- dm_req_write  in  1  1 = write, 0 = read.
- dm_req_addr  in  ADDR_SIZE  Data address.
- dm_req_wdata  in  WORD_SIZE  Write data.
- dm_req_ready  out  1  Data request accepted this cycle.
- dm_rsp_valid  out  1  One-cycle data response pulse.
- dm_rsp_rdata  out  WORD_SIZE  Read data (0 for writes).
- dm_rsp_err  out  1  Data access timed out.
- readM  out  1  Memory read strobe.
- writeM  out  1  Memory write strobe.
- address  out  ADDR_SIZE  Memory address.
- data  inout  WORD_SIZE  Shared data bus; driven only in WR, otherwise high-Z.
- inputReady  in  1  Memory read data valid on data.
- ackOutput  in  1  Memory has accepted the write.

Behaviour:
- Reset (async): state IDLE; readM, writeM, address, all rsp_valid/rsp_data/rsp_err = 0; data = Z; round-robin pointer favours data. A transaction in flight is abandoned with no response.
- States: IDLE, RD, WR, TURN.
- IDLE:
  - req_ready is combinational and asserted only for the winning valid channel.
  - Accept happens on edge N when valid & ready; address, wdata, direction and channel are latched.
  - Next state is RD (reads and all fetches) or WR.
- Arbitration:
  - ARB_MODE 0: data wins any tie.
  - ARB_MODE 1: on a tie, grant the channel not granted last; the pointer updates on every accept.
- RD:
  - readM = 1 and address = latched value, both registered and valid from the cycle after N.
  - On the first edge with inputReady = 1: capture data into the channel's rsp_data, pulse rsp_valid for exactly one cycle, then go to TURN.
- WR:
  - writeM = 1; data bus driven with latched wdata.
  - On the first edge with ackOutput = 1: pulse dm_rsp_valid with rdata = 0, then go to TURN.
- Timeout (TIMEOUT > 0):
  - The wait counter clears on entry to RD/WR and increments each cycle.
  - When it reaches TIMEOUT with no handshake: rsp_valid = 1 and rsp_err = 1, rsp_data = 0, go to TURN.
  - A handshake on the same edge as the timeout wins; err = 0.
- TURN: one cycle with readM = writeM = 0, bus at Z, req_ready = 0; then IDLE. This guarantees strobe deassertion between back-to-back accesses.
- Stray handshakes: ackOutput during RD, inputReady during WR, and either one in IDLE/TURN are ignored.
- Responses:
  - rsp_data and rsp_err hold their value until the next response on that channel.
  - Only one channel pulses rsp_valid in any cycle.
- Latency: minimum read (inputReady on the first RD edge) is accept at edge N, rsp_valid high in cycle N+2, next accept at edge N+3.
- The request side must hold valid and payload stable until ready; the controller never drops an accepted request.

Decomposition:
- Shared include file mem_defs.v holds:
  - state encodings (IDLE/RD/WR/TURN);
  - ARB_MODE constants;
  - channel IDs (CH_IF = 0, CH_DM = 1).
- One sub-module, mem_arbiter: 2-way fixed/round-robin grant logic with the last-grant register. Inputs are two valid bits, an enable and the mode; outputs are one-hot grants.

Test Plan:
- Fetch read: if_req addr 0x0010; memory asserts inputReady with 0xA5C3 after 3 cycles -> readM high for 3 cycles, if_rsp_valid one cycle, if_rsp_data = 0xA5C3, err = 0.
- Data write: addr 0x0040, wdata 0x1234, ackOutput after 2 cycles -> writeM high for 2 cycles, data = 0x1234 only while writeM is high, dm_rsp_valid pulse, data = Z in TURN.
- Simultaneous requests, ARB_MODE 0 -> data served first, then fetch. ARB_MODE 1 with both held for 4 transactions -> grant order DM, IF, DM, IF.
- TIMEOUT = 4, memory silent -> rsp_valid with err = 1 and rdata = 0 after 4 RD cycles; inputReady arriving on the timeout edge -> err = 0 and data captured.
- Reset asserted mid-WR -> writeM = 0 and data = Z immediately; no rsp_valid; after release, a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_port_ctrl_pkg.sv
// Shared definitions for the memory port controller: FSM state encoding,
// arbitration mode values and channel identifiers.
package mem_port_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    localparam logic CH_IF = 1'b0;
    localparam logic CH_DM = 1'b1;

endpackage

// File: rtl/mem_port_ctrl_arbiter.sv
// Two-way request arbiter: fixed data priority or round-robin, with a
// last-grant register that updates on every grant.
module mem_arbiter
    import mem_port_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic mode,
    input  logic valid_if,
    input  logic valid_dm,
    output logic gnt_if,
    output logic gnt_dm
);

    logic last_dm;
    logic pick_dm;

    // Reset leaves last_dm = 0 so the first round-robin tie goes to data.
    always_comb begin
        pick_dm = valid_dm;
        if (valid_dm && valid_if) begin
            pick_dm = (mode == ARB_RR) ? ~last_dm : 1'b1;
        end
        gnt_dm = en & valid_dm & pick_dm;
        gnt_if = en & valid_if & ~pick_dm;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dm <= 1'b0;
        end else if (gnt_if || gnt_dm) begin
            last_dm <= gnt_dm;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port controller: arbitrates fetch and data channels onto one shared
// memory bus, one handshaked transaction at a time, with optional timeout.
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int TIMEOUT   = 255,
    parameter int ARB_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req_valid,
    input  logic [ADDR_SIZE-1:0] if_req_addr,
    output logic                 if_req_ready,
    output logic                 if_rsp_valid,
    output logic [WORD_SIZE-1:0] if_rsp_data,
    output logic                 if_rsp_err,
    input  logic                 dm_req_valid,
    input  logic                 dm_req_write,
    input  logic [ADDR_SIZE-1:0] dm_req_addr,
    input  logic [WORD_SIZE-1:0] dm_req_wdata,
    output logic                 dm_req_ready,
    output logic                 dm_rsp_valid,
    output logic [WORD_SIZE-1:0] dm_rsp_rdata,
    output logic                 dm_rsp_err,
    output logic                 readM,
    output logic                 writeM,
    output logic [ADDR_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output state_t               dbg_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t               state;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 ch_q;
    logic [CW-1:0]        wait_cnt;
    logic                 gnt_if;
    logic                 gnt_dm;
    logic                 timed_out;
    logic                 rsp_fire;
    logic                 rsp_err_c;
    logic [WORD_SIZE-1:0] rsp_word;

    mem_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .en       (state == ST_IDLE),
        .mode     ((ARB_MODE == 1) ? ARB_RR : ARB_FIXED),
        .valid_if (if_req_valid),
        .valid_dm (dm_req_valid),
        .gnt_if   (gnt_if),
        .gnt_dm   (gnt_dm)
    );

    assign if_req_ready = gnt_if;
    assign dm_req_ready = gnt_dm;
    assign dbg_state    = state;

    // writeM is high exactly in WR, so it doubles as the bus output enable.
    assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

    // A handshake on the timeout edge takes precedence over the error.
    always_comb begin
        timed_out = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
        rsp_fire  = 1'b0;
        rsp_err_c = 1'b0;
        rsp_word  = '0;
        case (state)
            ST_RD: begin
                if (inputReady) begin
                    rsp_fire = 1'b1;
                    rsp_word = data;
                end else if (timed_out) begin
                    rsp_fire  = 1'b1;
                    rsp_err_c = 1'b1;
                end
            end
            ST_WR: begin
                if (ackOutput) begin
                    rsp_fire = 1'b1;
                end else if (timed_out) begin
                    rsp_fire  = 1'b1;
                    rsp_err_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            readM        <= 1'b0;
            writeM       <= 1'b0;
            address      <= '0;
            wdata_q      <= '0;
            ch_q         <= CH_IF;
            wait_cnt     <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
            dm_rsp_valid <= 1'b0;
            dm_rsp_rdata <= '0;
            dm_rsp_err   <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (gnt_dm) begin
                        address <= dm_req_addr;
                        wdata_q <= dm_req_wdata;
                        ch_q    <= CH_DM;
                        if (dm_req_write) begin
                            writeM <= 1'b1;
                            state  <= ST_WR;
                        end else begin
                            readM <= 1'b1;
                            state <= ST_RD;
                        end
                    end else if (gnt_if) begin
                        address <= if_req_addr;
                        ch_q    <= CH_IF;
                        readM   <= 1'b1;
                        state   <= ST_RD;
                    end
                end
                ST_RD, ST_WR: begin
                    if (rsp_fire) begin
                        readM  <= 1'b0;
                        writeM <= 1'b0;
                        state  <= ST_TURN;
                        if (ch_q == CH_DM) begin
                            dm_rsp_valid <= 1'b1;
                            dm_rsp_rdata <= rsp_word;
                            dm_rsp_err   <= rsp_err_c;
                        end else begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= rsp_word;
                            if_rsp_err   <= rsp_err_c;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: one fixed-priority instance with a short
// timeout driven by a scripted memory, one round-robin instance with an echo memory.
module tb_mem_port_ctrl;
    import mem_port_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // Instance A: ARB_MODE 0, TIMEOUT 4
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [15:0] if_req_addr, if_rsp_data;
    logic        dm_req_valid, dm_req_write, dm_req_ready, dm_rsp_valid, dm_rsp_err;
    logic [15:0] dm_req_addr, dm_req_wdata, dm_rsp_rdata;
    logic        readM, writeM, inputReady, ackOutput;
    logic [15:0] address;
    wire  [15:0] data;
    logic        mem_oe;
    logic [15:0] mem_val;
    state_t      dbg_state;

    assign data = mem_oe ? mem_val : 16'bz;

    mem_port_ctrl #(.WORD_SIZE(16), .ADDR_SIZE(16), .TIMEOUT(4), .ARB_MODE(0)) dut_a (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .dm_req_valid(dm_req_valid), .dm_req_write(dm_req_write), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready), .dm_rsp_valid(dm_rsp_valid),
        .dm_rsp_rdata(dm_rsp_rdata), .dm_rsp_err(dm_rsp_err),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput), .dbg_state(dbg_state)
    );

    // Instance B: ARB_MODE 1, timeout disabled, memory answers on the first edge
    logic        b_if_req_valid, b_if_req_ready, b_if_rsp_valid, b_if_rsp_err;
    logic [15:0] b_if_req_addr, b_if_rsp_data;
    logic        b_dm_req_valid, b_dm_req_ready, b_dm_rsp_valid, b_dm_rsp_err;
    logic [15:0] b_dm_req_addr, b_dm_rsp_rdata;
    logic        b_readM, b_writeM;
    logic [15:0] b_address;
    wire  [15:0] b_data;
    state_t      b_dbg_state;

    assign b_data = b_readM ? 16'h5A5A : 16'bz;

    mem_port_ctrl #(.WORD_SIZE(16), .ADDR_SIZE(16), .TIMEOUT(0), .ARB_MODE(1)) dut_b (
        .clk(clk), .reset(reset),
        .if_req_valid(b_if_req_valid), .if_req_addr(b_if_req_addr), .if_req_ready(b_if_req_ready),
        .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data), .if_rsp_err(b_if_rsp_err),
        .dm_req_valid(b_dm_req_valid), .dm_req_write(1'b0), .dm_req_addr(b_dm_req_addr),
        .dm_req_wdata(16'h0000), .dm_req_ready(b_dm_req_ready), .dm_rsp_valid(b_dm_rsp_valid),
        .dm_rsp_rdata(b_dm_rsp_rdata), .dm_rsp_err(b_dm_rsp_err),
        .readM(b_readM), .writeM(b_writeM), .address(b_address), .data(b_data),
        .inputReady(b_readM), .ackOutput(b_writeM), .dbg_state(b_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory driver: called on the negedge of the first strobe cycle; raises the
    // handshake in strobe cycle 'delay' (0 = never) and returns on the first
    // negedge with the strobe low, counting the strobe-high cycles seen.
    task automatic mem_wait(input int delay, input logic [15:0] word, output int strobe_cnt);
        strobe_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!(readM || writeM)) break;
            strobe_cnt++;
            if (c == delay) begin
                if (readM) begin
                    mem_oe     = 1'b1;
                    mem_val    = word;
                    inputReady = 1'b1;
                end else begin
                    ackOutput = 1'b1;
                end
            end
            @(negedge clk);
            inputReady = 1'b0;
            ackOutput  = 1'b0;
            mem_oe     = 1'b0;
        end
    endtask

    task automatic test_reset;
        total++; if (readM !== 1'b0) begin bad++; $display("FAIL reset_readM got=%0h exp=0", readM); end
        total++; if (writeM !== 1'b0) begin bad++; $display("FAIL reset_writeM got=%0h exp=0", writeM); end
        total++; if (address !== 16'h0000) begin bad++; $display("FAIL reset_address got=%h exp=0000", address); end
        total++; if ({if_rsp_valid, dm_rsp_valid, if_rsp_err, dm_rsp_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_rsp_flags got=%b exp=0000", {if_rsp_valid, dm_rsp_valid, if_rsp_err, dm_rsp_err});
        end
        total++; if ({if_rsp_data, dm_rsp_rdata} !== 32'h0) begin
            bad++; $display("FAIL reset_rsp_data got=%h exp=00000000", {if_rsp_data, dm_rsp_rdata});
        end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_read;
        int n;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0010;
        #1;
        total++; if ({if_req_ready, dm_req_ready} !== 2'b10) begin
            bad++; $display("FAIL fetch_ready got=%b exp=10", {if_req_ready, dm_req_ready});
        end
        @(negedge clk);
        if_req_valid = 1'b0;
        total++; if (readM !== 1'b1 || address !== 16'h0010) begin
            bad++; $display("FAIL fetch_strobe got=%0h/%h exp=1/0010", readM, address);
        end
        mem_wait(3, 16'hA5C3, n);
        total++; if (n != 3) begin bad++; $display("FAIL fetch_readM_cycles got=%0d exp=3", n); end
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 16'hA5C3 || if_rsp_err !== 1'b0) begin
            bad++; $display("FAIL fetch_rsp got=%0h/%h/%0h exp=1/a5c3/0", if_rsp_valid, if_rsp_data, if_rsp_err);
        end
        total++; if (dm_rsp_valid !== 1'b0) begin bad++; $display("FAIL fetch_dm_quiet got=%0h exp=0", dm_rsp_valid); end
        @(negedge clk);
        total++; if (if_rsp_valid !== 1'b0 || if_rsp_data !== 16'hA5C3) begin
            bad++; $display("FAIL fetch_pulse_hold got=%0h/%h exp=0/a5c3", if_rsp_valid, if_rsp_data);
        end
    endtask

    task automatic test_arb_fixed;
        int n;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0100;
        dm_req_valid = 1'b1;
        dm_req_write = 1'b0;
        dm_req_addr  = 16'h0200;
        #1;
        total++; if ({if_req_ready, dm_req_ready} !== 2'b01) begin
            bad++; $display("FAIL arb0_tie got=%b exp=01", {if_req_ready, dm_req_ready});
        end
        @(negedge clk);
        dm_req_valid = 1'b0;
        total++; if (address !== 16'h0200) begin bad++; $display("FAIL arb0_dm_addr got=%h exp=0200", address); end
        mem_wait(1, 16'h2222, n);
        total++; if (dm_rsp_valid !== 1'b1 || dm_rsp_rdata !== 16'h2222 || if_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL arb0_dm_rsp got=%0h/%h/%0h exp=1/2222/0", dm_rsp_valid, dm_rsp_rdata, if_rsp_valid);
        end
        total++; if (if_req_ready !== 1'b0 || dbg_state !== ST_TURN) begin
            bad++; $display("FAIL arb0_turn got=%0h/%0d exp=0/3", if_req_ready, dbg_state);
        end
        @(negedge clk);
        total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL arb0_if_next got=%0h exp=1", if_req_ready); end
        @(negedge clk);
        if_req_valid = 1'b0;
        total++; if (address !== 16'h0100) begin bad++; $display("FAIL arb0_if_addr got=%h exp=0100", address); end
        mem_wait(1, 16'h1111, n);
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 16'h1111 || dm_rsp_rdata !== 16'h2222) begin
            bad++; $display("FAIL arb0_if_rsp got=%0h/%h/%h exp=1/1111/2222", if_rsp_valid, if_rsp_data, dm_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_data_write;
        int n;
        dm_req_valid = 1'b1;
        dm_req_write = 1'b1;
        dm_req_addr  = 16'h0040;
        dm_req_wdata = 16'h1234;
        #1;
        total++; if (dm_req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%0h exp=1", dm_req_ready); end
        @(negedge clk);
        dm_req_valid = 1'b0;
        dm_req_wdata = 16'hFFFF;
        total++; if (writeM !== 1'b1 || readM !== 1'b0 || address !== 16'h0040) begin
            bad++; $display("FAIL wr_strobe got=%0h/%0h/%h exp=1/0/0040", writeM, readM, address);
        end
        total++; if (data !== 16'h1234) begin bad++; $display("FAIL wr_bus got=%h exp=1234", data); end
        mem_wait(2, 16'h0000, n);
        total++; if (n != 2) begin bad++; $display("FAIL wr_writeM_cycles got=%0d exp=2", n); end
        total++; if (dm_rsp_valid !== 1'b1 || dm_rsp_rdata !== 16'h0000 || dm_rsp_err !== 1'b0) begin
            bad++; $display("FAIL wr_rsp got=%0h/%h/%0h exp=1/0000/0", dm_rsp_valid, dm_rsp_rdata, dm_rsp_err);
        end
        mem_oe  = 1'b1;
        mem_val = 16'h0000;
        #1;
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL wr_bus_released got=%h exp=0000", data); end
        mem_oe = 1'b0;
        @(negedge clk);
        dm_req_write = 1'b0;
    endtask

    task automatic test_timeout;
        int n;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0020;
        @(negedge clk);
        if_req_valid = 1'b0;
        mem_wait(0, 16'h0000, n);
        total++; if (n != 4) begin bad++; $display("FAIL to_rd_cycles got=%0d exp=4", n); end
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_err !== 1'b1 || if_rsp_data !== 16'h0000) begin
            bad++; $display("FAIL to_rd_rsp got=%0h/%0h/%h exp=1/1/0000", if_rsp_valid, if_rsp_err, if_rsp_data);
        end
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0030;
        @(negedge clk);
        if_req_valid = 1'b0;
        mem_wait(4, 16'hBEEF, n);
        total++; if (n != 4 || if_rsp_valid !== 1'b1 || if_rsp_err !== 1'b0 || if_rsp_data !== 16'hBEEF) begin
            bad++; $display("FAIL to_race got=%0d/%0h/%0h/%h exp=4/1/0/beef", n, if_rsp_valid, if_rsp_err, if_rsp_data);
        end
        @(negedge clk);
        dm_req_valid = 1'b1;
        dm_req_write = 1'b1;
        dm_req_addr  = 16'h0050;
        dm_req_wdata = 16'h9999;
        @(negedge clk);
        dm_req_valid = 1'b0;
        mem_wait(0, 16'h0000, n);
        total++; if (n != 4 || dm_rsp_valid !== 1'b1 || dm_rsp_err !== 1'b1 || dm_rsp_rdata !== 16'h0000) begin
            bad++; $display("FAIL to_wr got=%0d/%0h/%0h/%h exp=4/1/1/0000", n, dm_rsp_valid, dm_rsp_err, dm_rsp_rdata);
        end
        @(negedge clk);
        dm_req_write = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        int n;
        dm_req_valid = 1'b1;
        dm_req_write = 1'b1;
        dm_req_addr  = 16'h0060;
        dm_req_wdata = 16'h5555;
        @(negedge clk);
        dm_req_valid = 1'b0;
        total++; if (writeM !== 1'b1) begin bad++; $display("FAIL rst_wr_started got=%0h exp=1", writeM); end
        reset = 1'b1;
        #1;
        total++; if (writeM !== 1'b0 || dbg_state !== ST_IDLE) begin
            bad++; $display("FAIL rst_async got=%0h/%0d exp=0/0", writeM, dbg_state);
        end
        mem_oe  = 1'b1;
        mem_val = 16'h0000;
        #1;
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL rst_bus_released got=%h exp=0000", data); end
        mem_oe = 1'b0;
        @(negedge clk);
        ackOutput = 1'b1;
        reset     = 1'b0;
        @(negedge clk);
        ackOutput = 1'b0;
        total++; if (dm_rsp_valid !== 1'b0 || dm_rsp_err !== 1'b0 || writeM !== 1'b0) begin
            bad++; $display("FAIL rst_no_rsp got=%0h/%0h/%0h exp=0/0/0", dm_rsp_valid, dm_rsp_err, writeM);
        end
        dm_req_write = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0070;
        @(negedge clk);
        if_req_valid = 1'b0;
        mem_wait(2, 16'h7777, n);
        total++; if (n != 2 || if_rsp_valid !== 1'b1 || if_rsp_data !== 16'h7777 || if_rsp_err !== 1'b0) begin
            bad++; $display("FAIL rst_fresh_fetch got=%0d/%0h/%h/%0h exp=2/1/7777/0", n, if_rsp_valid, if_rsp_data, if_rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_arb_rr;
        logic exp_q[$];
        logic exp_ch;
        logic got_ch;
        bit   found;
        exp_q = '{CH_DM, CH_IF, CH_DM, CH_IF};
        b_if_req_valid = 1'b1;
        b_if_req_addr  = 16'h0A00;
        b_dm_req_valid = 1'b1;
        b_dm_req_addr  = 16'h0B00;
        #1;
        while (exp_q.size() > 0) begin
            exp_ch = exp_q.pop_front();
            found  = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                if (b_if_req_ready || b_dm_req_ready) found = 1'b1;
                else @(negedge clk);
            end
            got_ch = b_dm_req_ready ? CH_DM : CH_IF;
            total++; if (!found || (b_if_req_ready && b_dm_req_ready) || got_ch !== exp_ch) begin
                bad++; $display("FAIL rr_grant got=%0b/%0b found=%0b exp_dm=%0b", b_if_req_ready, b_dm_req_ready, found, exp_ch);
            end
            @(negedge clk);
        end
        b_if_req_valid = 1'b0;
        b_dm_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (b_if_rsp_data !== 16'h5A5A || b_dm_rsp_rdata !== 16'h5A5A || b_if_rsp_err !== 1'b0 || b_dm_rsp_err !== 1'b0) begin
            bad++; $display("FAIL rr_rsp got=%h/%h/%0h/%0h exp=5a5a/5a5a/0/0", b_if_rsp_data, b_dm_rsp_rdata, b_if_rsp_err, b_dm_rsp_err);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_write = 1'b0; dm_req_addr = '0; dm_req_wdata = '0;
        inputReady = 1'b0; ackOutput = 1'b0; mem_oe = 1'b0; mem_val = '0;
        b_if_req_valid = 1'b0; b_if_req_addr = '0;
        b_dm_req_valid = 1'b0; b_dm_req_addr = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_fetch_read;
        test_arb_fixed;
        test_data_write;
        test_timeout;
        test_reset_mid_write;
        test_arb_rr;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
